// File: rtl/arp_tx_v2.sv
// ARP frame transmitter onto an 8-bit GMII TX interface.
// Accepts one request at a time over valid/ready, builds the Ethernet/ARP
// frame byte by byte, appends the CRC-32 FCS and then holds an inter-frame gap.
module arp_tx_v2 #(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned MIN_PAYLOAD  = 46,
    parameter int unsigned IFG_CYCLES   = 12,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [47:0]      local_mac,
    input  logic [31:0]      local_ip,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_type,
    input  logic [47:0]      req_mac,
    input  logic [31:0]      req_ip,
    output logic             gmii_tx_en,
    output logic [7:0]       gmii_txd,
    output logic             tx_busy,
    output logic             tx_done,
    output logic [CNT_W-1:0] tx_frame_cnt
);

    typedef enum logic [2:0] {IDLE, PRE, HEAD, DATA, FCS, IFG} state_t;

    localparam logic [5:0] PRE_LAST  = 6'(PREAMBLE_LEN);
    localparam logic [5:0] HEAD_LAST = 6'd13;
    localparam logic [5:0] DATA_LAST = 6'(MIN_PAYLOAD - 1);
    localparam logic [5:0] FCS_LAST  = 6'd3;
    localparam logic [7:0] IFG_LAST  = 8'(IFG_CYCLES - 1);

    state_t      state, state_nx;
    logic [5:0]  cnt;
    logic [7:0]  ifg_cnt;
    logic [31:0] crc;
    logic [31:0] fcs;
    logic        crc_en;
    logic [7:0]  data_byte;

    logic [47:0] r_lmac, r_rmac;
    logic [31:0] r_lip, r_rip;
    logic        r_type;

    // Byte i (0 = most significant) of a MAC address.
    function automatic logic [7:0] mac_byte(input logic [47:0] m, input logic [5:0] i);
        logic [7:0] b;
        b = '0;
        case (i)
            6'd0: b = m[47:40];
            6'd1: b = m[39:32];
            6'd2: b = m[31:24];
            6'd3: b = m[23:16];
            6'd4: b = m[15:8];
            6'd5: b = m[7:0];
            default: b = '0;
        endcase
        return b;
    endfunction

    // Byte i (0 = most significant) of an IPv4 address.
    function automatic logic [7:0] ip_byte(input logic [31:0] a, input logic [5:0] i);
        logic [7:0] b;
        b = '0;
        case (i)
            6'd0: b = a[31:24];
            6'd1: b = a[23:16];
            6'd2: b = a[15:8];
            6'd3: b = a[7:0];
            default: b = '0;
        endcase
        return b;
    endfunction

    // Reflected CRC-32 update over one byte, LSB first.
    function automatic logic [31:0] crc_next(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = c[0] ^ d[i];
            c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
        end
        return c;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // ARP payload byte for the current DATA position, padding included.
    always_comb begin
        data_byte = '0;
        if (cnt == 6'd1 || cnt == 6'd3 || cnt == 6'd6) data_byte = '0;
        if (cnt == 6'd1) data_byte = 8'h01;
        else if (cnt == 6'd2) data_byte = 8'h08;
        else if (cnt == 6'd4) data_byte = 8'h06;
        else if (cnt == 6'd5) data_byte = 8'h04;
        else if (cnt == 6'd7) data_byte = r_type ? 8'h02 : 8'h01;
        else if (cnt >= 6'd8 && cnt < 6'd14)  data_byte = mac_byte(r_lmac, cnt - 6'd8);
        else if (cnt >= 6'd14 && cnt < 6'd18) data_byte = ip_byte(r_lip, cnt - 6'd14);
        else if (cnt >= 6'd18 && cnt < 6'd24) data_byte = r_type ? mac_byte(r_rmac, cnt - 6'd18) : 8'h00;
        else if (cnt >= 6'd24 && cnt < 6'd28) data_byte = ip_byte(r_rip, cnt - 6'd24);
    end

    // Next-state logic and GMII/handshake outputs decoded from state.
    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        gmii_tx_en = 1'b0;
        gmii_txd   = '0;
        tx_busy    = 1'b1;
        tx_done    = 1'b0;
        crc_en     = 1'b0;
        fcs        = ~crc;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                tx_busy   = 1'b0;
                if (req_valid) state_nx = PRE;
            end
            PRE: begin
                gmii_tx_en = 1'b1;
                gmii_txd   = (cnt == PRE_LAST) ? 8'hD5 : 8'h55;
                if (cnt == PRE_LAST) state_nx = HEAD;
            end
            HEAD: begin
                gmii_tx_en = 1'b1;
                crc_en     = 1'b1;
                if (cnt < 6'd6)       gmii_txd = r_type ? mac_byte(r_rmac, cnt) : 8'hFF;
                else if (cnt < 6'd12) gmii_txd = mac_byte(r_lmac, cnt - 6'd6);
                else if (cnt == 6'd12) gmii_txd = 8'h08;
                else                   gmii_txd = 8'h06;
                if (cnt == HEAD_LAST) state_nx = DATA;
            end
            DATA: begin
                gmii_tx_en = 1'b1;
                crc_en     = 1'b1;
                gmii_txd   = data_byte;
                if (cnt == DATA_LAST) state_nx = FCS;
            end
            FCS: begin
                gmii_tx_en = 1'b1;
                case (cnt)
                    6'd0:    gmii_txd = fcs[7:0];
                    6'd1:    gmii_txd = fcs[15:8];
                    6'd2:    gmii_txd = fcs[23:16];
                    default: gmii_txd = fcs[31:24];
                endcase
                if (cnt == FCS_LAST) state_nx = IFG;
            end
            IFG: begin
                tx_done = (ifg_cnt == 8'd0);
                if (ifg_cnt == IFG_LAST) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Byte position within the current frame section; restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 cnt <= '0;
        else if (state_nx != state) cnt <= '0;
        else if (state != IDLE && state != IFG) cnt <= cnt + 6'd1;
    end

    // Inter-frame gap length counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            ifg_cnt <= '0;
        else if (state == IFG) ifg_cnt <= ifg_cnt + 8'd1;
        else                   ifg_cnt <= '0;
    end

    // CRC accumulates each HEAD/DATA byte in the cycle it is driven; reseeded at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        crc <= '1;
        else if (state == IDLE && req_valid) crc <= '1;
        else if (crc_en)                   crc <= crc_next(crc, gmii_txd);
    end

    // Request fields and local addresses frozen at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lmac <= '0;
            r_lip  <= '0;
            r_rmac <= '0;
            r_rip  <= '0;
            r_type <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            r_lmac <= local_mac;
            r_lip  <= local_ip;
            r_rmac <= req_mac;
            r_rip  <= req_ip;
            r_type <= req_type;
        end
    end

    // Completed-frame counter, visible in the first IFG cycle together with tx_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            tx_frame_cnt <= '0;
        else if (state == FCS && state_nx == IFG) tx_frame_cnt <= tx_frame_cnt + 1'b1;
    end

endmodule

// File: tb/tb_arp_tx_v2.sv
// Bench for arp_tx_v2: DUT 0 at default parameters, DUT 1 with a short
// preamble, long payload and single-cycle gap. A timeline model predicts
// every output on every cycle; directed tests add literal byte checks.
module tb_arp_tx_v2;

    logic        clk;
    logic        rst_n;
    logic [47:0] local_mac [2];
    logic [31:0] local_ip  [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_type  [2];
    logic [47:0] req_mac   [2];
    logic [31:0] req_ip    [2];
    logic        gmii_tx_en [2];
    logic [7:0]  gmii_txd   [2];
    logic        tx_busy    [2];
    logic        tx_done    [2];
    logic [15:0] tx_frame_cnt [2];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    arp_tx_v2 dut0 (
        .clk(clk), .rst_n(rst_n),
        .local_mac(local_mac[0]), .local_ip(local_ip[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_type(req_type[0]), .req_mac(req_mac[0]), .req_ip(req_ip[0]),
        .gmii_tx_en(gmii_tx_en[0]), .gmii_txd(gmii_txd[0]),
        .tx_busy(tx_busy[0]), .tx_done(tx_done[0]), .tx_frame_cnt(tx_frame_cnt[0])
    );

    arp_tx_v2 #(.PREAMBLE_LEN(1), .MIN_PAYLOAD(60), .IFG_CYCLES(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .local_mac(local_mac[1]), .local_ip(local_ip[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_type(req_type[1]), .req_mac(req_mac[1]), .req_ip(req_ip[1]),
        .gmii_tx_en(gmii_tx_en[1]), .gmii_txd(gmii_txd[1]),
        .tx_busy(tx_busy[1]), .tx_done(tx_done[1]), .tx_frame_cnt(tx_frame_cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pre(input int d);  return (d == 1) ? 1 : 7;   endfunction
    function automatic int pay(input int d);  return (d == 1) ? 60 : 46; endfunction
    function automatic int ifg(input int d);  return (d == 1) ? 1 : 12;  endfunction
    function automatic int flen(input int d); return pre(d) + 1 + 14 + pay(d) + 4; endfunction

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB88320;
            else             c = c >> 1;
        end
        return c;
    endfunction

    // Whole frame built from the request fields; returns byte number pos.
    function automatic logic [7:0] exp_byte(input int d, input int pos, input logic typ,
                                            input logic [47:0] lm, input logic [31:0] li,
                                            input logic [47:0] rm, input logic [31:0] ri);
        logic [7:0]  q[$];
        logic [31:0] c;
        for (int i = 0; i < pre(d); i++) q.push_back(8'h55);
        q.push_back(8'hD5);
        for (int i = 0; i < 6; i++) q.push_back(typ ? rm[47-8*i -: 8] : 8'hFF);
        for (int i = 0; i < 6; i++) q.push_back(lm[47-8*i -: 8]);
        q.push_back(8'h08); q.push_back(8'h06);
        q.push_back(8'h00); q.push_back(8'h01); q.push_back(8'h08); q.push_back(8'h00);
        q.push_back(8'h06); q.push_back(8'h04); q.push_back(8'h00);
        q.push_back(typ ? 8'h02 : 8'h01);
        for (int i = 0; i < 6; i++) q.push_back(lm[47-8*i -: 8]);
        for (int i = 0; i < 4; i++) q.push_back(li[31-8*i -: 8]);
        for (int i = 0; i < 6; i++) q.push_back(typ ? rm[47-8*i -: 8] : 8'h00);
        for (int i = 0; i < 4; i++) q.push_back(ri[31-8*i -: 8]);
        while (q.size() < pre(d) + 1 + 14 + pay(d)) q.push_back(8'h00);
        c = 32'hFFFFFFFF;
        for (int i = pre(d) + 1; i < q.size(); i++) c = crc_byte(c, q[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) q.push_back(c[8*i +: 8]);
        return q[pos];
    endfunction

    // Timeline model: position since accept, completed frames, sampled fields.
    logic        m_active [2];
    int          m_pos    [2];
    logic [15:0] m_cnt    [2];
    int          m_acc    [2];
    logic        m_typ    [2];
    logic [47:0] m_lm     [2];
    logic [31:0] m_li     [2];
    logic [47:0] m_rm     [2];
    logic [31:0] m_ri     [2];

    initial begin
        m_acc[0] = 0;
        m_acc[1] = 0;
    end

    // Model advance; accepts when idle and the request is valid.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_active[d] <= 1'b0;
                m_pos[d]    <= 0;
                m_cnt[d]    <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_active[d]) begin
                    m_pos[d] <= m_pos[d] + 1;
                    if (m_pos[d] + 1 == flen(d)) m_cnt[d] <= m_cnt[d] + 16'd1;
                    if (m_pos[d] + 1 == flen(d) + ifg(d)) m_active[d] <= 1'b0;
                end else if (req_valid[d]) begin
                    m_active[d] <= 1'b1;
                    m_pos[d]    <= 0;
                    m_acc[d]    <= m_acc[d] + 1;
                    m_typ[d]    <= req_type[d];
                    m_lm[d]     <= local_mac[d];
                    m_li[d]     <= local_ip[d];
                    m_rm[d]     <= req_mac[d];
                    m_ri[d]     <= req_ip[d];
                end
            end
        end
    end

    // Frame capture and gap measurement state.
    logic [7:0] cap [2][128];
    int         cap_len [2];
    int         idx [2];
    logic       en_prev [2];
    int         run [2];
    int         last_ifg [2];
    int         rise0[$];
    int         rise1[$];

    // Per-cycle compare against the model, plus capture of transmitted bytes.
    initial begin
        logic        e_en, e_busy, e_done, e_rdy;
        logic [7:0]  e_txd;
        for (int d = 0; d < 2; d++) begin
            idx[d] = 0; cap_len[d] = 0; en_prev[d] = 1'b0; run[d] = 0; last_ifg[d] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (rst_n) begin
                    e_en = 0; e_txd = 8'h00; e_busy = 0; e_done = 0; e_rdy = 0;
                    if (m_active[d]) begin
                        e_busy = 1;
                        if (m_pos[d] < flen(d)) begin
                            e_en  = 1;
                            e_txd = exp_byte(d, m_pos[d], m_typ[d], m_lm[d], m_li[d], m_rm[d], m_ri[d]);
                        end else begin
                            e_done = (m_pos[d] == flen(d));
                        end
                    end else begin
                        e_rdy = 1;
                    end
                    checks++;
                    if (gmii_tx_en[d] !== e_en || gmii_txd[d] !== e_txd || tx_busy[d] !== e_busy ||
                        tx_done[d] !== e_done || req_ready[d] !== e_rdy || tx_frame_cnt[d] !== m_cnt[d]) begin
                        errors++;
                        $display("FAIL cycle_dut%0d cyc=%0d pos=%0d: got en=%b txd=%h busy=%b done=%b ready=%b cnt=%0d, expected en=%b txd=%h busy=%b done=%b ready=%b cnt=%0d",
                                 d, cyc, m_pos[d], gmii_tx_en[d], gmii_txd[d], tx_busy[d], tx_done[d],
                                 req_ready[d], tx_frame_cnt[d], e_en, e_txd, e_busy, e_done, e_rdy, m_cnt[d]);
                    end
                end
                if (gmii_tx_en[d] && !en_prev[d]) begin
                    idx[d] = 0;
                    if (d == 0) rise0.push_back(cyc);
                    else        rise1.push_back(cyc);
                end
                if (gmii_tx_en[d]) begin
                    cap[d][idx[d]] = gmii_txd[d];
                    if (idx[d] < 127) idx[d]++;
                end
                if (!gmii_tx_en[d] && en_prev[d]) cap_len[d] = idx[d];
                if (!gmii_tx_en[d] && tx_busy[d]) run[d]++;
                else if (!tx_busy[d] && run[d] != 0) begin
                    last_ifg[d] = run[d];
                    run[d] = 0;
                end
                en_prev[d] = gmii_tx_en[d];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Running the CRC over data plus FCS of a good frame leaves the fixed residue.
    function automatic logic [31:0] residue(input int d);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = pre(d) + 1; i < cap_len[d]; i++) c = crc_byte(c, cap[d][i]);
        return c;
    endfunction

    task automatic send(input int d, input logic typ, input logic [47:0] lm, input logic [31:0] li,
                        input logic [47:0] rm, input logic [31:0] ri);
        int  acc0;
        bit  ok;
        local_mac[d] = lm; local_ip[d] = li; req_type[d] = typ; req_mac[d] = rm; req_ip[d] = ri;
        req_valid[d] = 1'b1;
        acc0 = m_acc[d];
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #2;
            if (m_acc[d] != acc0) begin ok = 1; break; end
        end
        req_valid[d] = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout dut%0d: got no accept, expected accept within 400 cycles", d);
        end
    endtask

    task automatic wait_idle(input int d);
        bit ok;
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            if (!m_active[d]) begin ok = 1; break; end
            @(posedge clk); #2;
        end
        @(negedge clk); #1;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle_timeout dut%0d: got busy, expected idle within 400 cycles", d);
        end
    endtask

    task automatic frame_ok(input int d, input string nm);
        chk({nm, "_len"}, 32'(cap_len[d]), 32'(flen(d)));
        chk({nm, "_fcs_residue"}, residue(d), 32'hDEBB20E3);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] c;
        logic [7:0]  vec [9];
        bit          ok;
        int          d;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            local_mac[i] = '0; local_ip[i] = '0; req_valid[i] = 1'b0;
            req_type[i] = 1'b0; req_mac[i] = '0; req_ip[i] = '0;
        end

        // Pin the bench CRC: standard check value of "123456789".
        vec = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 9; i++) c = crc_byte(c, vec[i]);
        chk("model_crc_check_value", ~c, 32'hCBF43926);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("reset_ready", 32'(req_ready[0]), 32'd1);
        chk("reset_tx_en", 32'(gmii_tx_en[0]), 32'd0);
        chk("reset_cnt", 32'(tx_frame_cnt[0]), 32'd0);
        @(posedge clk); #2;

        // Test 1: ARP request.
        send(0, 1'b0, 48'h001122334455, 32'hC0A8010A, 48'h0, 32'hC0A80166);
        wait_idle(0);
        frame_ok(0, "req");
        chk("req_sfd",        32'(cap[0][7]),  32'hD5);
        chk("req_dst0",       32'(cap[0][8]),  32'hFF);
        chk("req_src0",       32'(cap[0][14]), 32'h00);
        chk("req_src5",       32'(cap[0][19]), 32'h55);
        chk("req_ethtype",    {16'h0, cap[0][20], cap[0][21]}, 32'h0806);
        chk("req_oper",       32'(cap[0][29]), 32'h01);
        chk("req_sender_ip",  {cap[0][36], cap[0][37], cap[0][38], cap[0][39]}, 32'hC0A8010A);
        chk("req_target_mac", {cap[0][40], cap[0][41], cap[0][42], cap[0][43]}, 32'h0);
        chk("req_target_ip",  {cap[0][46], cap[0][47], cap[0][48], cap[0][49]}, 32'hC0A80166);
        chk("req_pad_last",   32'(cap[0][67]), 32'h00);
        chk("req_frame_cnt",  32'(tx_frame_cnt[0]), 32'd1);

        // Test 2: ARP reply.
        @(posedge clk); #2;
        send(0, 1'b1, 48'h001122334455, 32'hC0A8010A, 48'h66778899AABB, 32'hC0A80166);
        wait_idle(0);
        frame_ok(0, "rep");
        chk("rep_dst0",   32'(cap[0][8]),  32'h66);
        chk("rep_dst5",   32'(cap[0][13]), 32'hBB);
        chk("rep_oper",   32'(cap[0][29]), 32'h02);
        chk("rep_tmac0",  32'(cap[0][40]), 32'h66);
        chk("rep_tmac5",  32'(cap[0][45]), 32'hBB);
        chk("rep_cnt",    32'(tx_frame_cnt[0]), 32'd2);

        // Test 3: request held valid back to back.
        @(posedge clk); #2;
        rise0.delete();
        local_mac[0] = 48'h001122334455; local_ip[0] = 32'hC0A8010A;
        req_type[0] = 1'b0; req_ip[0] = 32'hC0A80167;
        req_valid[0] = 1'b1;
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #2;
            if (rise0.size() >= 3) begin ok = 1; break; end
        end
        req_valid[0] = 1'b0;
        chk("b2b_three_frames", 32'(ok), 32'd1);
        wait_idle(0);
        if (rise0.size() >= 3) begin
            chk("b2b_spacing_1", 32'(rise0[1] - rise0[0]), 32'd85);
            chk("b2b_spacing_2", 32'(rise0[2] - rise0[1]), 32'd85);
        end
        chk("b2b_ifg_len", 32'(last_ifg[0]), 32'd12);
        frame_ok(0, "b2b");

        // Test 4: inputs change right after accept.
        @(posedge clk); #2;
        send(0, 1'b0, 48'h02AABBCCDDEE, 32'h0A000001, 48'h0, 32'h0A000005);
        local_mac[0] = 48'h123456789ABC;
        req_ip[0]    = 32'h0B0B0B0B;
        wait_idle(0);
        frame_ok(0, "hold");
        chk("hold_src0",  32'(cap[0][14]), 32'h02);
        chk("hold_src5",  32'(cap[0][19]), 32'hEE);
        chk("hold_smac0", 32'(cap[0][30]), 32'h02);
        chk("hold_tip3",  32'(cap[0][49]), 32'h05);

        // Test 5: reset in the middle of a frame.
        @(posedge clk); #2;
        send(0, 1'b0, 48'h001122334455, 32'hC0A8010A, 48'h0, 32'hC0A80166);
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            if (m_pos[0] == 30) begin ok = 1; break; end
            @(posedge clk); #2;
        end
        chk("rst_reach_byte30", 32'(ok), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_tx_en_drop", 32'(gmii_tx_en[0]), 32'd0);
        chk("rst_txd_zero",   32'(gmii_txd[0]),   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rst_ready_after", 32'(req_ready[0]), 32'd1);
        chk("rst_cnt_cleared", 32'(tx_frame_cnt[0]), 32'd0);
        @(posedge clk); #2;
        send(0, 1'b1, 48'h0A0B0C0D0E0F, 32'hAC100001, 48'h665544332211, 32'hAC100002);
        wait_idle(0);
        frame_ok(0, "post_rst");
        chk("post_rst_cnt", 32'(tx_frame_cnt[0]), 32'd1);

        // Test 6: short preamble, long payload, one-cycle gap.
        d = 1;
        @(posedge clk); #2;
        send(d, 1'b0, 48'h001122334455, 32'hC0A8010A, 48'h0, 32'hC0A80166);
        wait_idle(d);
        frame_ok(d, "p6");
        chk("p6_pre",   32'(cap[1][0]),  32'h55);
        chk("p6_sfd",   32'(cap[1][1]),  32'hD5);
        chk("p6_dst0",  32'(cap[1][2]),  32'hFF);
        chk("p6_tip3",  32'(cap[1][43]), 32'h66);
        chk("p6_pad_first", 32'(cap[1][44]), 32'h00);
        chk("p6_pad_last",  32'(cap[1][75]), 32'h00);
        @(posedge clk); #2;
        rise1.delete();
        req_valid[1] = 1'b1;
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #2;
            if (rise1.size() >= 2) begin ok = 1; break; end
        end
        req_valid[1] = 1'b0;
        chk("p6_two_frames", 32'(ok), 32'd1);
        wait_idle(1);
        if (rise1.size() >= 2) chk("p6_spacing", 32'(rise1[1] - rise1[0]), 32'd82);
        chk("p6_ifg_len", 32'(last_ifg[1]), 32'd1);
        chk("p6_cnt", 32'(tx_frame_cnt[1]), 32'd3);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
